// File: rtl/uart_pkg.sv
// Shared UART receive types: state encoding, counter widths.
// Parity support in uart_rx_core is enabled by UART_RX_PARITY_EN.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  // Holds 0..9 data bits and the stop-bit index.
  localparam int BCNT_W = 4;

  function automatic int cnt_w(input int ovs);
    return (ovs > 1) ? $clog2(ovs) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-flop synchroniser, falling-edge detect
// and 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS = 16,
  localparam int CW = cnt_w(OVS)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          tick,
  input  logic [CW-1:0] cnt,
  input  logic          rx,
  output logic          rx_s,
  output logic          fall,
  output logic          vote,
  output logic          bit_dec
);

  localparam logic [CW-1:0] C_LO  = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(OVS/2);
  localparam logic [CW-1:0] C_HI  = CW'(OVS/2 + 1);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_smp;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_smp  <= 2'b00;
    end else begin
      r_meta <= rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (tick && cnt == C_LO)
        r_smp[0] <= r_sync;
      if (tick && cnt == C_MID)
        r_smp[1] <= r_sync;
    end
  end

  // Third sample is taken live on the deciding tick.
  assign rx_s    = r_sync;
  assign fall    = r_prev & ~r_sync;
  assign bit_dec = tick & (cnt == C_HI);
  assign vote    = (r_smp[0] & r_smp[1]) |
                   (r_smp[0] & r_sync)   |
                   (r_smp[1] & r_sync);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start detect, LSB-first capture, 1/2 stop bits.
// Optional parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  input  logic              rx_en,
  input  logic              tick,
  input  logic              rx,
  input  logic              par_odd,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              break_det,
  output logic              busy
);

  localparam int CW = cnt_w(OVS);
  localparam logic [CW-1:0]     C_END  = CW'(OVS - 1);
  localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_W - 1);
  localparam logic [BCNT_W-1:0] B_STOP = BCNT_W'(STOP_BITS - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_ferr;

  logic w_rx_s;
  logic w_fall;
  logic w_vote;
  logic w_bit_dec;
  logic w_bit_end;
  logic w_unused_rx;

  uart_rx_sampler #(
    .OVS(OVS)
  ) u_sampler (
    .clk     (clk),
    .arst_n  (arst_n),
    .tick    (tick),
    .cnt     (r_cnt),
    .rx      (rx),
    .rx_s    (w_rx_s),
    .fall    (w_fall),
    .vote    (w_vote),
    .bit_dec (w_bit_dec)
  );

  assign w_unused_rx = w_rx_s;
  assign w_bit_end   = tick & (r_cnt == C_END);
  assign busy        = (r_state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic r_perr;
`else
  logic w_unused_par;
  assign w_unused_par = par_odd;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_ferr    <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr     <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rst || !rx_en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_bcnt  <= '0;
      end else begin
        if (r_state != IDLE && tick)
          r_cnt <= (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
        unique case (r_state)
          IDLE: begin
            if (w_fall) begin
              r_state <= START;
              r_cnt   <= '0;
              r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_perr  <= 1'b0;
`endif
            end
          end
          START: begin
            if (w_bit_dec && w_vote) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (w_bit_end) begin
              r_state <= DATA;
              r_bcnt  <= '0;
            end
          end
          DATA: begin
            if (w_bit_dec)
              r_shift <= {w_vote, r_shift[DATA_W-1:1]};
            if (w_bit_end) begin
              if (r_bcnt == B_LAST) begin
                r_bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_bit_dec)
              r_perr <= w_vote ^ (^r_shift) ^ par_odd;
            if (w_bit_end)
              r_state <= STOP;
          end
`endif
          STOP: begin
            if (w_bit_dec) begin
              if (!w_vote)
                r_ferr <= 1'b1;
              // Finish on the final stop bit's centre to catch a quick restart.
              if (r_bcnt == B_STOP) begin
                valid     <= 1'b1;
                data_out  <= r_shift;
                frame_err <= r_ferr | ~w_vote;
                break_det <= (r_shift == '0) & (r_ferr | ~w_vote);
`ifdef UART_RX_PARITY_EN
                parity_err <= r_perr;
`endif
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_bcnt    <= '0;
              end
            end else if (w_bit_end) begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core (1 and 2 stop-bit instances).
module tb_uart_rx_core;

  localparam int DW  = 8;
  localparam int OVS = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic par_odd = 1'b0;
  logic rx = 1'b1;
  logic rx_en = 1'b1;
  logic rx2 = 1'b1;
  logic rx_en2 = 1'b1;

  logic [DW-1:0] dout, dout2;
  logic val, fe, pe, bd, busy;
  logic val2, fe2, pe2, bd2, busy2;

  int errors = 0;
  int checks = 0;
  int nv1 = 0;
  int nv2 = 0;
  int flagviol = 0;
  logic [7:0] last1 = 8'h00;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       bd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  bit   lv[$];

  uart_rx_core #(.DATA_W(DW), .OVS(OVS), .STOP_BITS(1)) u_dut (
    .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en),
    .tick(tick), .rx(rx), .par_odd(par_odd),
    .data_out(dout), .valid(val), .frame_err(fe),
    .parity_err(pe), .break_det(bd), .busy(busy)
  );

  uart_rx_core #(.DATA_W(DW), .OVS(OVS), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .arst_n(arst_n), .rst(rst), .rx_en(rx_en2),
    .tick(tick), .rx(rx2), .par_odd(par_odd),
    .data_out(dout2), .valid(val2), .frame_err(fe2),
    .parity_err(pe2), .break_det(bd2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic pv1 = 1'b0;
  logic pv2 = 1'b0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (val) begin : m1
        exp_t e;
        nv1++;
        if (pv1) flagviol++;
        if (q1.size() == 0) chk("valid_unexp", 1, 0);
        else begin
          e = q1.pop_front();
          chk("data", dout, e.d);
          chk("frame_err", fe, e.fe);
          chk("parity_err", pe, e.pe);
          chk("break_det", bd, e.bd);
        end
      end else if (fe | pe | bd) flagviol++;
      if (val2) begin : m2
        exp_t e;
        nv2++;
        if (pv2) flagviol++;
        if (q2.size() == 0) chk("valid2_unexp", 1, 0);
        else begin
          e = q2.pop_front();
          chk("data2", dout2, e.d);
          chk("frame_err2", fe2, e.fe);
          chk("parity_err2", pe2, e.pe);
          chk("break_det2", bd2, e.bd);
        end
      end else if (fe2 | pe2 | bd2) flagviol++;
      pv1 = val;
      pv2 = val2;
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!tick) @(posedge clk);
  endtask

  task automatic add_bit(input bit b);
    repeat (OVS) lv.push_back(b);
  endtask

  task automatic add_gap(input int n);
    repeat (n) lv.push_back(1'b1);
  endtask

  // Reference frame: expected result follows from the bits on the wire.
  task automatic add_frame(input bit sel, input logic [7:0] d,
                           input bit stop0, input bit pbit);
    exp_t e;
    int   sb;
    sb = sel ? 2 : 1;
    add_bit(1'b0);
    for (int i = 0; i < DW; i++) add_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    add_bit(pbit);
    e.pe = (pbit != ((^d) ^ par_odd));
`else
    e.pe = 1'b0;
`endif
    for (int s = 0; s < sb; s++) add_bit(!(stop0 && s == sb - 1));
    e.d  = d;
    e.fe = stop0;
    e.bd = stop0 && (d == 8'h00);
    if (sel) q2.push_back(e);
    else begin
      q1.push_back(e);
      last1 = d;
    end
  endtask

  task automatic send(input bit sel);
    for (int i = 0; i < lv.size(); i++) begin
      wait_tick();
      @(negedge clk);
      if (sel) rx2 = lv[i];
      else rx = lv[i];
    end
    wait_tick();
    lv.delete();
  endtask

  int n0;
  int base;
  int idx;
  logic [7:0] rd;
  bit st0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", dout, 0);
    chk("rst_valid", val, 0);
    chk("rst_ferr", fe, 0);
    chk("rst_perr", pe, 0);
    chk("rst_break", bd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy2", busy2, 0);
    arst_n = 1'b1;
    repeat (4) wait_tick();

    n0 = nv1;
    add_frame(0, 8'hA5, 0, 1'b0);
    add_gap(4);
    send(0);
    @(negedge clk);
    chk("a5_count", nv1 - n0, 1);
    chk("a5_data", dout, 8'hA5);
    chk("a5_busy", busy, 0);

    n0 = nv1;
    repeat (4) lv.push_back(1'b0);
    repeat (4) lv.push_back(1'b1);
    send(0);
    @(negedge clk);
    chk("fs_busy_mid", busy, 1);
    add_gap(2 * OVS);
    send(0);
    @(negedge clk);
    chk("fs_busy_end", busy, 0);
    chk("fs_no_valid", nv1 - n0, 0);

    n0 = nv1;
    add_frame(0, 8'h00, 1, 1'b0);
    add_gap(4);
    add_frame(0, 8'h3C, 1, 1'b0);
    add_gap(4);
    send(0);
    chk("stop0_count", nv1 - n0, 2);

    base = lv.size();
    add_frame(0, 8'h5A, 0, 1'b0);
    lv[base + OVS + OVS/2] = 1'b1;
    add_gap(4);
    send(0);
    chk("glitch_data", dout, 8'h5A);

    par_odd = 1'b1;
    add_frame(0, 8'h07, 0, 1'b1);
    add_gap(4);
    add_frame(0, 8'h07, 0, 1'b0);
    add_gap(4);
    send(0);

    n0 = nv1;
    add_bit(1'b0);
    add_bit(1'b1);
    add_bit(1'b0);
    add_bit(1'b1);
    send(0);
    @(negedge clk);
    chk("abort_busy_mid", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    add_gap(2 * OVS);
    send(0);
    chk("abort_no_valid", nv1 - n0, 0);
    chk("abort_hold", dout, last1);

    for (int b = 0; b < 2; b++) begin
      par_odd = b[0];
      n0 = nv1;
      for (int f = 0; f < 15; f++) begin
        rd  = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
        st0 = ($urandom_range(4) == 0);
        base = lv.size();
        add_frame(0, rd, st0, 1'($urandom));
        if ($urandom_range(1) == 1) begin
          idx = base + OVS * (1 + $urandom_range(DW - 1))
                + OVS/2 - 1 + $urandom_range(2);
          lv[idx] = ~lv[idx];
        end
        add_gap(st0 ? $urandom_range(12, 2) : $urandom_range(12, 0));
      end
      send(0);
      chk("rand_count", nv1 - n0, 15);
    end
    chk("q1_empty", q1.size(), 0);

    par_odd = 1'b0;
    add_frame(1, 8'h81, 0, 1'b0);
    add_bit(1'b0);
    add_bit(1'b1);
    add_bit(1'b0);
    add_bit(1'b0);
    send(1);
    @(negedge clk);
    chk("sb2_busy_mid", busy2, 1);
    rx_en2 = 1'b0;
    @(posedge clk);
    #1;
    chk("sb2_busy_off", busy2, 0);
    rx2 = 1'b1;
    repeat (2 * OVS) wait_tick();
    chk("sb2_count", nv2, 1);
    chk("sb2_hold", dout2, 8'h81);
    rx_en2 = 1'b1;
    repeat (4) wait_tick();
    add_frame(1, 8'h00, 1, 1'b0);
    add_gap(6);
    add_frame(1, 8'($urandom), 0, 1'b0);
    add_gap(4);
    send(1);
    chk("sb2_total", nv2, 3);
    chk("q2_empty", q2.size(), 0);
    chk("flags_idle", flagviol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Parametrised UART receive engine: oversampled start detection, majority-vote bit sampling, LSB-first data capture, 1 or 2 stop bits, frame/break error reporting.
- Sits between the baud-rate tick generator and the APB-side RX buffer/register file.
- Owns its own sample counter and bit counter. Needs no external count input.
- Emits one result pulse per received frame.

Parameters:
- DATA_W, 8: data bits per frame; legal 5..9.
- OVS, 16: oversample ticks per bit; even, >= 8.
- STOP_BITS, 1: stop bits checked; legal 1 or 2.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- rst  in  1  synchronous clear to IDLE; outputs held.
- rx_en  in  1  receiver enable; low forces IDLE.
- tick  in  1  oversample strobe, one clk wide, OVS per bit period.
- rx  in  1  serial input, asynchronous.
- par_odd  in  1  1 = odd parity, 0 = even; used only with parity feature.
- data_out  out  DATA_W  last received word; updated when valid is high.
- valid  out  1  one-cycle pulse at end of every completed frame.
- frame_err  out  1  qualified by valid: a stop bit sampled 0.
- parity_err  out  1  qualified by valid: parity mismatch.
- break_det  out  1  qualified by valid: all data bits 0 and frame_err set.
- busy  out  1  state != IDLE.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on port arst_n. These are fixed.
- Reset values: data_out=0, valid=0, frame_err=0, parity_err=0, break_det=0, busy=0, state=IDLE, synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s). A falling-edge detect on rx_s starts a frame. rx-to-detect latency is 3 clk.
- Sample counter: cnt 0..OVS-1. Advances only on tick. Wraps OVS-1 -> 0 and generates bit_end on that tick.
- Majority vote: samples taken on ticks with cnt = OVS/2-1, OVS/2 and OVS/2+1. Bit value = 2-of-3. The decision (bit_dec) is made on the OVS/2+1 tick.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on rx_s falling edge; cnt cleared to 0.
- START: on bit_dec, if the vote is 1 it is a false start -> IDLE, with no valid. Otherwise stay until bit_end, then go to DATA with bit counter = 0.
- DATA: on bit_dec, shift the voted bit in at the MSB, shifting right, so the result is LSB-first. On bit_end, increment the bit counter. When the bit counter reaches DATA_W, go to PARITY if the feature is compiled in, else STOP.
- PARITY: on bit_dec, compare the voted bit with XOR(data) ^ par_odd and latch the mismatch. On bit_end -> STOP.
- STOP: on bit_dec of each stop bit, a vote of 0 sets the latched frame error.
  - STOP_BITS=2: the first stop bit's bit_end moves to the second stop bit.
  - On bit_dec of the final stop bit: pulse valid, load data_out and the error flags, -> IDLE.
  - The bus does not wait for the final bit_end, so a start edge half a bit later is caught.
- Error flags and break_det are driven only in the valid cycle and are 0 otherwise.
- Latched error state clears on entry to START.
- rst or ~rx_en (synchronous): state -> IDLE next clk, counters cleared, no valid.
  - data_out holds its value; busy=0 one cycle later.
  - rst has priority over everything except arst_n.
- tick and the rx edge in the same cycle while IDLE: the edge wins, and cnt counts from the next tick.
- A falling edge while not IDLE is ignored.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state exists, one parity bit follows the data, par_odd selects the parity sense, and parity_err is live.
- Undefined: there is no PARITY state, DATA goes directly to STOP, par_odd is ignored, and parity_err is tied 0.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
  - a helper for the counter width clog2(OVS);
  - the bit-counter width constant.
- One sub-module, uart_rx_sampler, holds the 2-flop synchroniser, the falling-edge detect and the 3-sample majority voter. Its outputs are rx_s, fall, vote and bit_dec.
- The FSM, counters, shift register and flag logic stay in uart_rx_core.

Test Plan:
- Defaults, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single valid pulse, data_out=0xA5, frame_err=0, break_det=0, busy low afterwards.
- rx low for 4 ticks then high -> false start; busy drops after the OVS/2+1 tick; no valid.
- Frame 0x00 with stop bit 0 -> valid with frame_err=1 and break_det=1. Repeat with data 0x3C -> frame_err=1, break_det=0.
- Frame 0x5A with a one-tick high glitch on the OVS/2 sample of bit 0 -> majority rejects it; data_out=0x5A.
- UART_RX_PARITY_EN, par_odd=1, data 0x07, parity bit 1 -> parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- STOP_BITS=2, two back-to-back 0x81 frames; drop rx_en mid-way through the second frame -> exactly one valid (0x81); busy=0 one clk after rx_en low; data_out remains 0x81.
